// File: rtl/pe_lane_if.sv
// pe_lane_if: bundles the job-control, weight-beat and result handshakes of
// pe_lane_array.
//   start/len/bias : job start pulse, beat count and per-lane signed bias
//   abort          : synchronous job cancel
//   in_valid/in_ready/spike/weights : weight beat stream
//   out_valid/out_ready/out_sum/out_sat : per-lane result handshake
//   busy           : block is not idle
// master = job source / result consumer, slave = pe_lane_array.
interface pe_lane_if #(
  parameter int LANES = 8,
  parameter int BW_W  = 8,
  parameter int BW_PS = 16,
  parameter int LEN_W = 10
);
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic [LANES*BW_W-1:0]    bias;
  logic                     abort;
  logic                     in_valid;
  logic                     in_ready;
  logic                     spike;
  logic [LANES*BW_W-1:0]    weights;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*BW_PS-1:0]   out_sum;
  logic [LANES-1:0]         out_sat;
  logic                     busy;

  modport master (
    output start, len, bias, abort, in_valid, spike, weights, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, busy
  );

  modport slave (
    input  start, len, bias, abort, in_valid, spike, weights, out_ready,
    output in_ready, out_valid, out_sum, out_sat, busy
  );
endinterface

// File: rtl/pe_lane_array.sv
// pe_lane_array: LANES parallel saturating accumulators driven by a stream of
// binary-spike weight beats. A job loads the per-lane bias, accepts len beats
// (adding the beat's weights only when spike=1), then presents the per-lane
// sums and sticky saturation flags until the consumer accepts them.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pe_lane_if.slave (start/len/bias/abort, beat stream, result, busy)
module pe_lane_array #(
  parameter int LANES = 8,
  parameter int BW_W  = 8,
  parameter int BW_PS = 16,
  parameter int LEN_W = 10
) (
  input  logic      clk,
  input  logic      rst,
  pe_lane_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] ONE_LEN = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [LANES*BW_PS-1:0]   acc_q, acc_d;
  logic [LANES-1:0]         sat_q, sat_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     beat_s;
  logic                     last_beat_s;
  logic [BW_PS:0]           lane_sum_s;
  logic                     in_ready_s;
  logic                     out_valid_s;
  logic                     busy_s;

  // Sign-extend a lane weight/bias to partial-sum width.
  function automatic logic [BW_PS-1:0] sext(input logic [BW_W-1:0] v);
    return {{(BW_PS-BW_W){v[BW_W-1]}}, v};
  endfunction

  // Saturating signed add. Bit BW_PS of the result flags a clamp; the lower
  // BW_PS bits hold the (possibly clamped) sum.
  function automatic logic [BW_PS:0] sat_add(input logic [BW_PS-1:0] a,
                                             input logic [BW_PS-1:0] b);
    logic [BW_PS:0] s;
    logic [BW_PS:0] r;
    s = {a[BW_PS-1], a} + {b[BW_PS-1], b};
    if (s[BW_PS] != s[BW_PS-1]) begin
      if (s[BW_PS]) begin
        r = {1'b1, 1'b1, {(BW_PS-1){1'b0}}};
      end else begin
        r = {1'b1, 1'b0, {(BW_PS-1){1'b1}}};
      end
    end else begin
      r = {1'b0, s[BW_PS-1:0]};
    end
    return r;
  endfunction

  // in_ready depends only on state, so a beat is accepted whenever ACC sees in_valid.
  assign beat_s      = (state_q == S_ACC) && bus.in_valid;
  assign last_beat_s = (cnt_q == (len_q - ONE_LEN));

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sat_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = (bus.len != {LEN_W{1'b0}}) ? S_ACC : S_OUT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ACC: begin
          if (beat_s && last_beat_s) begin
            state_d = S_OUT;
          end else begin
            state_d = S_ACC;
          end
        end
        S_OUT: begin
          // A start in the handshake cycle is dropped: IDLE only honours it next cycle.
          if (bus.out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_OUT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Accumulator, saturation, beat counter and length datapath.
  always_comb begin
    acc_d      = acc_q;
    sat_d      = sat_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    lane_sum_s = '0;
    if (bus.abort) begin
      acc_d = '0;
      sat_d = '0;
      cnt_d = '0;
    end else if ((state_q == S_IDLE) && bus.start) begin
      for (int i = 0; i < LANES; i++) begin
        acc_d[i*BW_PS +: BW_PS] = sext(bus.bias[i*BW_W +: BW_W]);
      end
      sat_d = '0;
      cnt_d = '0;
      len_d = bus.len;
    end else if (beat_s) begin
      cnt_d = cnt_q + ONE_LEN;
      if (bus.spike) begin
        for (int i = 0; i < LANES; i++) begin
          lane_sum_s = sat_add(acc_q[i*BW_PS +: BW_PS], sext(bus.weights[i*BW_W +: BW_W]));
          acc_d[i*BW_PS +: BW_PS] = lane_sum_s[BW_PS-1:0];
          sat_d[i] = sat_q[i] | lane_sum_s[BW_PS];
        end
      end else begin
        acc_d = acc_q;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
      S_ACC: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
      end
      S_OUT: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.busy      = busy_s;
  // Result registers are the accumulators themselves, so they hold through IDLE.
  assign bus.out_sum   = acc_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_pe_lane_array.sv
// tb_pe_lane_array: directed bench for pe_lane_array (LANES=4, BW_W=8,
// BW_PS=16). A job-level model (integer sums, clamp, beats remaining) is
// compared against every DUT output on each falling edge; hand-computed
// literals pin the model at the end of each scenario.
module tb_pe_lane_array;
  localparam int LANES = 4;
  localparam int BW_W  = 8;
  localparam int BW_PS = 16;
  localparam int LEN_W = 10;

  logic clk;
  logic rst;
  pe_lane_if #(.LANES(LANES), .BW_W(BW_W), .BW_PS(BW_PS), .LEN_W(LEN_W)) bus ();

  pe_lane_array #(.LANES(LANES), .BW_W(BW_W), .BW_PS(BW_PS), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Job-level model state
  bit m_accepting;
  bit m_result;
  int m_left;
  int m_sum [LANES];
  bit m_sat [LANES];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    logic [7:0] x0, x1, x2, x3;
    x0 = a[7:0];
    x1 = b[7:0];
    x2 = c[7:0];
    x3 = d[7:0];
    return {x3, x2, x1, x0};
  endfunction

  // Model: advances on each rising edge from the inputs presented in that cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_accepting = 1'b0;
      m_result    = 1'b0;
      m_left      = 0;
      for (int i = 0; i < LANES; i++) begin m_sum[i] = 0; m_sat[i] = 1'b0; end
    end else if (bus.abort) begin
      m_accepting = 1'b0;
      m_result    = 1'b0;
      m_left      = 0;
      for (int i = 0; i < LANES; i++) begin m_sum[i] = 0; m_sat[i] = 1'b0; end
    end else if (!m_accepting && !m_result) begin
      if (bus.start) begin
        for (int i = 0; i < LANES; i++) begin
          m_sum[i] = $signed(bus.bias[i*BW_W +: BW_W]);
          m_sat[i] = 1'b0;
        end
        m_left = int'(bus.len);
        if (m_left == 0) m_result = 1'b1;
        else m_accepting = 1'b1;
      end
    end else if (m_accepting) begin
      if (bus.in_valid) begin
        if (bus.spike) begin
          for (int i = 0; i < LANES; i++) begin
            int s;
            s = m_sum[i] + int'($signed(bus.weights[i*BW_W +: BW_W]));
            if (s > 32767) begin s = 32767; m_sat[i] = 1'b1; end
            else if (s < -32768) begin s = -32768; m_sat[i] = 1'b1; end
            m_sum[i] = s;
          end
        end
        m_left--;
        if (m_left == 0) begin
          m_accepting = 1'b0;
          m_result    = 1'b1;
        end
      end
    end else begin
      if (bus.out_ready) m_result = 1'b0;
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, m_accepting});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_result});
      check("busy", {31'd0, bus.busy}, {31'd0, (m_accepting | m_result)});
      for (int i = 0; i < LANES; i++) begin
        check($sformatf("out_sum%0d", i), {16'd0, bus.out_sum[i*BW_PS +: BW_PS]},
              {16'd0, m_sum[i][15:0]});
        check($sformatf("out_sat%0d", i), {31'd0, bus.out_sat[i]}, {31'd0, m_sat[i]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.len = '0; bus.bias = '0; bus.abort = 1'b0;
    bus.in_valid = 1'b0; bus.spike = 1'b0; bus.weights = '0; bus.out_ready = 1'b0;
  endtask

  task automatic start_job(input logic [31:0] b, input int n);
    bus.bias = b;
    bus.len = n[LEN_W-1:0];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_sum", bus.out_sum[31:0], 32'd0);

    // Basic: lane0 5 + (-2) + (spike 0) 100 = 3; lane1 10+20 = 30
    start_job(32'd0, 3);
    bus.in_valid = 1'b1;
    bus.spike = 1'b1; bus.weights = pack4(5, 10, -1, 127);  tick();
    bus.spike = 1'b1; bus.weights = pack4(-2, 20, -1, 127); tick();
    bus.spike = 1'b0; bus.weights = pack4(100, 50, 9, 9);   tick();
    bus.in_valid = 1'b0;
    check("basic_valid", {31'd0, bus.out_valid}, 32'd1);
    check("basic_lane0", {16'd0, bus.out_sum[15:0]}, 32'd3);
    check("basic_lane1", {16'd0, bus.out_sum[31:16]}, 32'd30);
    check("basic_sat", {28'd0, bus.out_sat}, 32'd0);
    check("model_lane0", m_sum[0], 32'd3);
    handshake();
    check("basic_hold", {16'd0, bus.out_sum[15:0]}, 32'd3);

    // len=0 with bias lane2 = -7: result the next cycle
    start_job(pack4(1, 2, -7, 3), 0);
    check("len0_valid", {31'd0, bus.out_valid}, 32'd1);
    check("len0_lane2", {16'd0, bus.out_sum[47:32]}, 32'h0000_FFF9);
    check("len0_ready", {31'd0, bus.in_ready}, 32'd0);
    handshake();

    // Saturation: lanes 0/1 climb past +32767, lanes 2/3 fall past -32768
    start_job(pack4(127, 127, -128, -128), 300);
    bus.in_valid = 1'b1; bus.spike = 1'b1;
    bus.weights = pack4(127, 127, -128, -128);
    for (int k = 0; k < 300; k++) tick();
    bus.in_valid = 1'b0;
    check("sat_lane0", {16'd0, bus.out_sum[15:0]}, 32'h0000_7FFF);
    check("sat_lane2", {16'd0, bus.out_sum[47:32]}, 32'h0000_8000);
    check("sat_flags", {28'd0, bus.out_sat}, 32'h0000_000F);
    handshake();

    // Backpressure: toggling in_valid, start ignored in ACC/OUT, result held
    start_job(32'd0, 4);
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = (k % 2 == 0);
      bus.spike = 1'b1;
      bus.start = 1'b1; bus.len = '0;
      bus.weights = pack4(k/2 + 1, -(k/2 + 1), 50, 0);
      tick();
    end
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("bp_lane0", {16'd0, bus.out_sum[15:0]}, 32'd10);
    check("bp_lane1", {16'd0, bus.out_sum[31:16]}, 32'h0000_FFF6);
    check("bp_lane2", {16'd0, bus.out_sum[47:32]}, 32'd200);
    check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    handshake();
    bus.start = 1'b0; bus.in_valid = 1'b0;
    check("bp_start_in_hs", {31'd0, bus.busy}, 32'd0);
    tick();

    // Abort after beat 2 of 5, with start and a beat in the same cycle
    start_job(pack4(3, 0, 0, 0), 5);
    bus.in_valid = 1'b1; bus.spike = 1'b1; bus.weights = pack4(10, 1, 1, 1);
    tick(); tick();
    bus.abort = 1'b1; bus.start = 1'b1; bus.len = 10'd2;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_sum", bus.out_sum[31:0], 32'd0);
    check("abort_sum_hi", bus.out_sum[63:32], 32'd0);
    start_job(32'd0, 2);
    bus.in_valid = 1'b1;
    bus.weights = pack4(7, 0, 0, 0); tick();
    bus.weights = pack4(8, 0, 0, 0); tick();
    bus.in_valid = 1'b0;
    check("post_abort_lane0", {16'd0, bus.out_sum[15:0]}, 32'd15);
    check("post_abort_valid", {31'd0, bus.out_valid}, 32'd1);
    handshake();

    // Reset mid-job
    start_job(pack4(1, 1, 1, 1), 5);
    bus.in_valid = 1'b1; bus.weights = pack4(4, 4, 4, 4);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sum", bus.out_sum[31:0], 32'd0);
    check("rst_sat", {28'd0, bus.out_sat}, 32'd0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pe_lane_array.md
PE_LANE_ARRAY -- requirements
Module: pe_lane_array

Interface
REQ-001 Parameter: LANES, 8, number of parallel accumulator lanes (>=1).
REQ-002 Parameter: BW_W, 8, signed weight and bias width per lane.
REQ-003 Parameter: BW_PS, 16, signed partial-sum width per lane (BW_PS > BW_W).
REQ-004 Parameter: LEN_W, 10, width of the beat-count field.
REQ-005 Port: clk  in  1  clock; all logic on rising edge.
REQ-006 Port: rst  in  1  reset, synchronous, active-high.
REQ-007 Port: start  in  1  job start pulse; honoured only in IDLE.
REQ-008 Port: len  in  LEN_W  number of input beats in the job; sampled with start.
REQ-009 Port: bias  in  LANES*BW_W  signed per-lane bias; lane i at bits [i*BW_W +: BW_W]; sampled with start.
REQ-010 Port: abort  in  1  synchronous job cancel.
REQ-011 Port: in_valid  in  1  weight beat valid.
REQ-012 Port: in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-013 Port: spike  in  1  binary unit state for the beat; 1 = add weights, 0 = count the beat only.
REQ-014 Port: weights  in  LANES*BW_W  signed per-lane weights for the beat, same packing as bias.
REQ-015 Port: out_valid  out  1  result available.
REQ-016 Port: out_ready  in  1  consumer accepts the result.
REQ-017 Port: out_sum  out  LANES*BW_PS  signed per-lane sums; lane i at [i*BW_PS +: BW_PS].
REQ-018 Port: out_sat  out  LANES  per-lane sticky saturation flag for the job.
REQ-019 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, ACC, OUT.
REQ-021 IDLE: on start, acc[i] <= sign-extended bias[i], sat[i] <= 0, cnt <= 0, len_q <= len; next state is ACC if len != 0, else OUT.
REQ-022 in_ready SHALL be 1 exactly when the state is ACC; it is combinational from the state only.
REQ-023 ACC: on each accepted beat, cnt <= cnt+1; if spike=1, acc[i] <= sat_add(acc[i], sign-extended weights[i]); if spike=0, acc is unchanged.
REQ-024 sat_add SHALL clamp to [-2^(BW_PS-1), 2^(BW_PS-1)-1] and SHALL set sat[i] on any clamp.
REQ-025 ACC: when the accepted beat has cnt == len_q-1, the next state is OUT; beats beyond len_q SHALL NOT be accepted.
REQ-026 OUT: out_valid=1, out_sum=acc, out_sat=sat, all stable until handshake; on out_ready the next state is IDLE.
REQ-027 out_sum and out_sat SHALL hold their last values in IDLE; out_valid=0 outside OUT.
REQ-028 Latency: out_valid SHALL rise the cycle after the last beat is accepted (one cycle after start when len=0).
REQ-029 start in ACC or OUT SHALL be ignored; start in the same cycle as the OUT-to-IDLE handshake SHALL be ignored.
REQ-030 abort (any state) SHALL force IDLE and clear acc, sat, cnt next cycle, and SHALL take priority over start, beats and handshake in that cycle.
REQ-031 All lanes SHALL operate in lockstep with identical timing; lane results SHALL be independent.
REQ-032 cnt SHALL be LEN_W bits wide; the maximum job length is 2^LEN_W-1 with no wrap-around.

Reset
REQ-033 On rst: state=IDLE, acc, sat, cnt, len_q=0, out_sum=0, out_sat=0, out_valid=0, in_ready=0, busy=0.
REQ-034 rst SHALL take priority over abort and all other inputs, including in the middle of a job.

Verification (LANES=4, BW_W=8, BW_PS=16)
REQ-035 Basic: bias all 0, len=3, spike 1,1,0, weights lane0 = 5,-2,100 -> out_sum lane0=3, out_valid high on the cycle after beat 3, out_sat=0.
REQ-036 Bias/len=0: bias lane2=-7, len=0, start -> out_valid the next cycle, lane2=-7, in_ready never high.
REQ-037 Saturation: bias=127, len=300, spike=1, weights=127 each beat -> lane sums clamp at 32767, out_sat=4'b1111; a negative case clamps at -32768.
REQ-038 Backpressure: in_valid toggling 1/0 and out_ready held 0 for 5 cycles -> out_sum stable, no extra beats accepted, start ignored while OUT.
REQ-039 Abort mid-job: abort after beat 2 of 5 -> IDLE next cycle with sums 0; a new job started afterwards yields a result unaffected by the aborted job.
REQ-040 Reset mid-job: rst in ACC -> all outputs at reset values next cycle, busy=0.
